seg7_frame_arbiter: RTL and testbench
=====================================

# seg7_frame_arbiter

Frame-buffer controller and arbiter for the 8-digit seven-segment scan driver. Two clients share the display: client A (high priority, e.g. status/alarm) and client B (low priority, e.g. message/score). Each client gets exclusive write access through a req/grant handshake, fills a shadow frame digit by digit, and atomically commits it. The block presents the active frame as eight 7-bit patterns that feed the scan driver's digit inputs directly.

## Interface
- HOLD_CYC, 1000: minimum cycles B keeps the display after its grant or last commit before A may preempt it; must be ≥1.
- iCLK  in  1  system clock, all logic on rising edge
- nRST  in  1  reset, synchronous, active-high (despite the name)
- iA_REQ  in  1  client A requests ownership (level)
- iA_WR  in  1  client A writes iA_PAT into shadow digit iA_IDX
- iA_IDX  in  3  digit index 0..7
- iA_PAT  in  7  segment pattern {a..g}
- iA_COMMIT  in  1  client A copies shadow to active frame
- oA_GNT  out  1  client A owns the display (registered)
- iB_REQ, iB_WR, iB_IDX[2:0], iB_PAT[6:0], iB_COMMIT  in  same meaning for client B
- oB_GNT  out  1  client B owns the display (registered)
- oSEG0..oSEG7  out  7 each  active frame digit 0..7, to scan driver
- oOWNER  out  2  00 none, 01 A, 10 B (equals {oB_GNT,oA_GNT})

## Operation
- State machine: IDLE, OWN_A, OWN_B. oA_GNT=1 only in OWN_A. oB_GNT=1 only in OWN_B.
- IDLE: iA_REQ → OWN_A. Otherwise iB_REQ → OWN_B. Otherwise stay. A wins a simultaneous request.
- OWN_A: iA_REQ low → IDLE. A is never preempted.
- OWN_B, evaluated in priority order:
  - iB_REQ low → IDLE.
  - iA_REQ high and hold counter = 0 → OWN_A directly (preemption, no idle cycle).
  - Otherwise stay.
- Hold counter (width clog2(HOLD_CYC)+1):
  - loads HOLD_CYC−1 on entry to OWN_B and on every B commit accepted in OWN_B;
  - otherwise decrements, saturating at 0.
- Shadow frame (8×7): loaded from the active frame on every transition into OWN_A or OWN_B. This discards any uncommitted writes from the previous owner.
- Writes: only the current owner's iX_WR is honoured; shadow[iX_IDX] ← iX_PAT. The non-owner's WR and COMMIT are ignored, with no error flag.
- Commit: only the owner's iX_COMMIT is honoured; active ← shadow. If WR and COMMIT are asserted in the same cycle, the write is included in the committed frame.
- On a release cycle (owner REQ low), that owner's WR/COMMIT are ignored.
- The active frame holds its value indefinitely after the owner releases or is preempted; ownership changes never blank the display.
- Reset: state IDLE; oA_GNT=oB_GNT=0; oOWNER=00; active and shadow frames all 7'b0000000; hold counter 0.

## Timing
- Grant latency: REQ sampled high at edge n with arbitration won → GNT high after edge n.
- The first honoured write is the edge after GNT rises: a WR asserted together with REQ in the same cycle is ignored.
- Release: REQ sampled low at edge n → GNT low after edge n. The next grant to the other client comes no earlier than edge n+1, so there is one idle cycle.
- Preemption: at the edge where the condition holds, oB_GNT falls and oA_GNT rises simultaneously.
- Commit: COMMIT sampled at edge k → oSEG0..7 show the new frame after edge k. All eight digits change on the same edge.
- Reset mid-transaction: all uncommitted and committed data is lost; outputs return to their reset values after the reset edge.
- Outputs are all registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then B requests; at the grant edge write IDX0..7 = 7'h01..7'h08 and commit with the last write. Expect oSEG0..7 = 01..08 one cycle after the commit, oOWNER=10.
- A and B raise REQ in the same cycle. Expect oA_GNT=1, oB_GNT=0. A releases → one idle cycle, then oB_GNT=1.
- B owns, HOLD_CYC=4, A requests 1 cycle after B's commit. Expect no preemption until the counter reaches 0, then the switch to A occurs with no idle cycle. B's uncommitted writes never appear, and A's shadow equals B's last committed frame.
- Non-owner A writes IDX3=7'h7F and commits while B owns. Expect the active frame and B's shadow unchanged.
- Owner writes IDX5=7'h3F with COMMIT in the same cycle. Expect oSEG5=7'h3F on the next cycle.
- Assert nRST mid-write while B owns. Expect GNTs=0, oOWNER=00, all oSEG=0 after the reset edge, and a clean grant to A on the next request.

Source files
------------

// File: rtl/seg7_frame_arbiter_if.sv
// Client-side bus of the seven-segment frame arbiter: two req/grant write
// ports plus the active frame and owner presented to the scan driver.
interface seg7_frame_arbiter_if;
  logic       iA_REQ;
  logic       iA_WR;
  logic [2:0] iA_IDX;
  logic [6:0] iA_PAT;
  logic       iA_COMMIT;
  logic       oA_GNT;
  logic       iB_REQ;
  logic       iB_WR;
  logic [2:0] iB_IDX;
  logic [6:0] iB_PAT;
  logic       iB_COMMIT;
  logic       oB_GNT;
  logic [6:0] oSEG0;
  logic [6:0] oSEG1;
  logic [6:0] oSEG2;
  logic [6:0] oSEG3;
  logic [6:0] oSEG4;
  logic [6:0] oSEG5;
  logic [6:0] oSEG6;
  logic [6:0] oSEG7;
  logic [1:0] oOWNER;

  modport master (
    output iA_REQ, iA_WR, iA_IDX, iA_PAT, iA_COMMIT,
    output iB_REQ, iB_WR, iB_IDX, iB_PAT, iB_COMMIT,
    input  oA_GNT, oB_GNT, oOWNER,
    input  oSEG0, oSEG1, oSEG2, oSEG3, oSEG4, oSEG5, oSEG6, oSEG7
  );

  modport slave (
    input  iA_REQ, iA_WR, iA_IDX, iA_PAT, iA_COMMIT,
    input  iB_REQ, iB_WR, iB_IDX, iB_PAT, iB_COMMIT,
    output oA_GNT, oB_GNT, oOWNER,
    output oSEG0, oSEG1, oSEG2, oSEG3, oSEG4, oSEG5, oSEG6, oSEG7
  );
endinterface

// File: rtl/seg7_frame_arbiter.sv
// Two-client frame buffer for the 8-digit seven-segment display: A has priority,
// B keeps the display for HOLD_CYC cycles after a grant or commit before A may preempt.
module seg7_frame_arbiter #(
  parameter int HOLD_CYC = 1000
) (
  input  logic                 iCLK,
  input  logic                 nRST,
  seg7_frame_arbiter_if.slave  bus
);
  localparam int              HW        = $clog2(HOLD_CYC) + 1;
  localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [HW-1:0] r_hold;
  logic          r_a_gnt;
  logic          r_b_gnt;
  logic [6:0]    r_active [8];
  logic [6:0]    r_shadow [8];
  logic [6:0]    w_merged [8];
  logic          w_wr_en;
  logic [2:0]    w_wr_idx;
  logic [6:0]    w_wr_pat;
  logic          w_commit;
  logic          w_b_commit;
  logic          w_enter;

  // Arbitration: A wins ties; B is preempted only once its hold time has run out.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.iA_REQ)      w_next = ST_OWN_A;
        else if (bus.iB_REQ) w_next = ST_OWN_B;
        else                 w_next = ST_IDLE;
      end
      ST_OWN_A: begin
        if (!bus.iA_REQ) w_next = ST_IDLE;
        else             w_next = ST_OWN_A;
      end
      ST_OWN_B: begin
        if (!bus.iB_REQ)                          w_next = ST_IDLE;
        else if (bus.iA_REQ && (r_hold == '0))    w_next = ST_OWN_A;
        else                                      w_next = ST_OWN_B;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Owner port select; a releasing owner (REQ low) gets nothing honoured.
  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_idx   = 3'd0;
    w_wr_pat   = 7'd0;
    w_commit   = 1'b0;
    w_b_commit = 1'b0;
    case (r_state)
      ST_OWN_A: begin
        w_wr_en  = bus.iA_REQ & bus.iA_WR;
        w_wr_idx = bus.iA_IDX;
        w_wr_pat = bus.iA_PAT;
        w_commit = bus.iA_REQ & bus.iA_COMMIT;
      end
      ST_OWN_B: begin
        w_wr_en    = bus.iB_REQ & bus.iB_WR;
        w_wr_idx   = bus.iB_IDX;
        w_wr_pat   = bus.iB_PAT;
        w_commit   = bus.iB_REQ & bus.iB_COMMIT;
        w_b_commit = bus.iB_REQ & bus.iB_COMMIT;
      end
      default: begin
        w_wr_en = 1'b0;
      end
    endcase
  end

  // Shadow with this cycle's write folded in, so WR+COMMIT commits the write too.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (w_wr_en && (w_wr_idx == 3'(i))) w_merged[i] = w_wr_pat;
      else                                 w_merged[i] = r_shadow[i];
    end
  end

  assign w_enter = (w_next != r_state) && (w_next != ST_IDLE);

  // State and registered grants.
  always_ff @(posedge iCLK) begin
    if (nRST) begin
      r_state <= ST_IDLE;
      r_a_gnt <= 1'b0;
      r_b_gnt <= 1'b0;
    end else begin
      r_state <= w_next;
      r_a_gnt <= (w_next == ST_OWN_A);
      r_b_gnt <= (w_next == ST_OWN_B);
    end
  end

  // B hold counter: reloads on B grant and on every accepted B commit.
  always_ff @(posedge iCLK) begin
    if (nRST) begin
      r_hold <= '0;
    end else if ((w_enter && (w_next == ST_OWN_B)) || w_b_commit) begin
      r_hold <= HOLD_LOAD;
    end else if (r_hold != '0) begin
      r_hold <= r_hold - HW'(1);
    end else begin
      r_hold <= r_hold;
    end
  end

  // Frames: a new owner starts from the (possibly just committed) active frame.
  always_ff @(posedge iCLK) begin
    for (int i = 0; i < 8; i++) begin
      if (nRST) begin
        r_active[i] <= 7'd0;
        r_shadow[i] <= 7'd0;
      end else begin
        if (w_commit) r_active[i] <= w_merged[i];
        else          r_active[i] <= r_active[i];
        if (w_enter)  r_shadow[i] <= w_commit ? w_merged[i] : r_active[i];
        else          r_shadow[i] <= w_merged[i];
      end
    end
  end

  assign bus.oA_GNT = r_a_gnt;
  assign bus.oB_GNT = r_b_gnt;
  assign bus.oOWNER = {r_b_gnt, r_a_gnt};
  assign bus.oSEG0  = r_active[0];
  assign bus.oSEG1  = r_active[1];
  assign bus.oSEG2  = r_active[2];
  assign bus.oSEG3  = r_active[3];
  assign bus.oSEG4  = r_active[4];
  assign bus.oSEG5  = r_active[5];
  assign bus.oSEG6  = r_active[6];
  assign bus.oSEG7  = r_active[7];
endmodule

// File: tb/tb_seg7_frame_arbiter.sv
// Scoreboard bench: a timestamp-based reference model predicts each cycle's
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_seg7_frame_arbiter;
  localparam int HOLD = 4;

  typedef struct packed {
    logic            a_gnt;
    logic            b_gnt;
    logic [1:0]      owner;
    logic [7:0][6:0] seg;
  } exp_t;

  logic iCLK;
  logic rst;
  seg7_frame_arbiter_if u_if();

  seg7_frame_arbiter #(.HOLD_CYC(HOLD)) u_dut (
    .iCLK (iCLK),
    .nRST (rst),
    .bus  (u_if.slave)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: owner 0 none / 1 A / 2 B, B's hold measured as cycles since its last grant or commit.
  int              m_owner = 0;
  int              m_cyc   = 0;
  int              m_bmark = 0;
  logic [7:0][6:0] m_active = '0;
  logic [7:0][6:0] m_shadow = '0;

  task automatic model_step();
    logic [7:0][6:0] tmp;
    int   nxt;
    logic wr, cm;
    logic [2:0] idx;
    logic [6:0] pat;
    exp_t e;
    m_cyc++;
    if (rst) begin
      m_owner  = 0;
      m_active = '0;
      m_shadow = '0;
    end else begin
      wr = 1'b0; cm = 1'b0; idx = 3'd0; pat = 7'd0;
      if (m_owner == 1 && u_if.iA_REQ) begin
        wr = u_if.iA_WR; cm = u_if.iA_COMMIT; idx = u_if.iA_IDX; pat = u_if.iA_PAT;
      end
      if (m_owner == 2 && u_if.iB_REQ) begin
        wr = u_if.iB_WR; cm = u_if.iB_COMMIT; idx = u_if.iB_IDX; pat = u_if.iB_PAT;
      end
      tmp = m_shadow;
      if (wr) tmp[idx] = pat;
      nxt = m_owner;
      if (m_owner == 0)      nxt = u_if.iA_REQ ? 1 : (u_if.iB_REQ ? 2 : 0);
      else if (m_owner == 1) nxt = u_if.iA_REQ ? 1 : 0;
      else if (!u_if.iB_REQ) nxt = 0;
      else if (u_if.iA_REQ && (m_cyc - m_bmark >= HOLD)) nxt = 1;
      else nxt = 2;
      if (cm) m_active = tmp;
      if (nxt == 2 && m_owner != 2) m_bmark = m_cyc;
      else if (m_owner == 2 && cm)  m_bmark = m_cyc;
      m_shadow = (nxt != m_owner && nxt != 0) ? m_active : tmp;
      m_owner  = nxt;
    end
    e.a_gnt = (m_owner == 1);
    e.b_gnt = (m_owner == 2);
    e.owner = {e.b_gnt, e.a_gnt};
    e.seg   = m_active;
    sb_q.push_back(e);
  endtask

  // Predict the next edge's result from the inputs now applied, then advance one cycle.
  task automatic tick();
    model_step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic clear_inputs();
    u_if.iA_WR = 1'b0; u_if.iA_IDX = 3'd0; u_if.iA_PAT = 7'd0; u_if.iA_COMMIT = 1'b0;
    u_if.iB_WR = 1'b0; u_if.iB_IDX = 3'd0; u_if.iB_PAT = 7'd0; u_if.iB_COMMIT = 1'b0;
  endtask

  // Monitor: compares every presented output cycle against the oldest prediction.
  always @(negedge iCLK) begin
    exp_t e;
    logic [7:0][6:0] act_seg;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      act_seg = {u_if.oSEG7, u_if.oSEG6, u_if.oSEG5, u_if.oSEG4,
                 u_if.oSEG3, u_if.oSEG2, u_if.oSEG1, u_if.oSEG0};
      checks++;
      if ({u_if.oA_GNT, u_if.oB_GNT} !== {e.a_gnt, e.b_gnt}) begin
        errors++;
        $display("FAIL gnt t=%0t: got A=%b B=%b, want A=%b B=%b",
                 $time, u_if.oA_GNT, u_if.oB_GNT, e.a_gnt, e.b_gnt);
      end
      checks++;
      if (u_if.oOWNER !== e.owner) begin
        errors++;
        $display("FAIL owner t=%0t: got %b, want %b", $time, u_if.oOWNER, e.owner);
      end
      checks++;
      if (act_seg !== e.seg) begin
        errors++;
        $display("FAIL frame t=%0t: got %h, want %h", $time, act_seg, e.seg);
      end
    end
  end

  initial begin
    rst = 1'b1;
    u_if.iA_REQ = 1'b0;
    u_if.iB_REQ = 1'b0;
    clear_inputs();
    tick(); tick();
    rst = 1'b0;
    tick();

    // B fills all eight digits, committing with the last write.
    u_if.iB_REQ = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      u_if.iB_WR = 1'b1; u_if.iB_IDX = 3'(i); u_if.iB_PAT = 7'(i + 1);
      u_if.iB_COMMIT = (i == 7);
      tick();
    end
    clear_inputs();
    tick();

    // Simultaneous request: A wins; on A's release one idle cycle precedes B.
    u_if.iB_REQ = 1'b0;
    tick(); tick();
    u_if.iA_REQ = 1'b1; u_if.iB_REQ = 1'b1;
    tick(); tick();
    u_if.iA_REQ = 1'b0;
    tick(); tick(); tick();

    // B commits, A asks one cycle later; B keeps writing but never commits again.
    u_if.iB_WR = 1'b1; u_if.iB_IDX = 3'd2; u_if.iB_PAT = 7'h55; u_if.iB_COMMIT = 1'b1;
    tick();
    clear_inputs();
    tick();
    u_if.iA_REQ = 1'b1;
    for (int i = 0; i < 6; i++) begin
      u_if.iB_WR = 1'b1; u_if.iB_IDX = 3'd0; u_if.iB_PAT = 7'h11;
      tick();
    end
    clear_inputs();
    u_if.iA_WR = 1'b1; u_if.iA_IDX = 3'd1; u_if.iA_PAT = 7'h22; u_if.iA_COMMIT = 1'b1;
    tick();
    clear_inputs();

    // A releases, B returns; then A as non-owner writes and commits.
    u_if.iA_REQ = 1'b0;
    tick(); tick(); tick();
    u_if.iA_WR = 1'b1; u_if.iA_IDX = 3'd3; u_if.iA_PAT = 7'h7F; u_if.iA_COMMIT = 1'b1;
    tick();
    clear_inputs();
    u_if.iB_COMMIT = 1'b1;
    tick();
    clear_inputs();

    // Owner write and commit in the same cycle.
    u_if.iB_WR = 1'b1; u_if.iB_IDX = 3'd5; u_if.iB_PAT = 7'h3F; u_if.iB_COMMIT = 1'b1;
    tick();
    clear_inputs();
    tick();

    // Reset in the middle of a B write, then a clean grant to A.
    u_if.iB_WR = 1'b1; u_if.iB_IDX = 3'd4; u_if.iB_PAT = 7'h44;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    u_if.iB_REQ = 1'b0;
    clear_inputs();
    tick();
    u_if.iA_REQ = 1'b1;
    tick(); tick();
    u_if.iA_REQ = 1'b0;
    tick();

    // Random traffic with sticky request levels.
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 19) == 0) u_if.iA_REQ = ~u_if.iA_REQ;
      if ($urandom_range(0, 14) == 0) u_if.iB_REQ = ~u_if.iB_REQ;
      u_if.iA_WR     = 1'($urandom_range(0, 1));
      u_if.iA_IDX    = 3'($urandom_range(0, 7));
      u_if.iA_PAT    = 7'($urandom_range(0, 127));
      u_if.iA_COMMIT = ($urandom_range(0, 5) == 0);
      u_if.iB_WR     = 1'($urandom_range(0, 1));
      u_if.iB_IDX    = 3'($urandom_range(0, 7));
      u_if.iB_PAT    = 7'($urandom_range(0, 127));
      u_if.iB_COMMIT = ($urandom_range(0, 5) == 0);
      rst            = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    clear_inputs();

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge iCLK);
    #6;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
